// File: rtl/attn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : attn_pkg
// Description : Shared types, default geometry and width helpers for the
//               attention token loader and its row bank.
// Revision    : 1.0 - initial release
// ============================================================================
package attn_pkg;

  // Default geometry. The loader parameters default to these values.
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TOKEN_DIM  = 4;
  localparam int DEF_TOKEN_NUM  = 8;
  localparam int DEF_MIN_HOLD   = 4;

  // Width helper that never returns zero, so 1-entry configurations still
  // get a legal 1-bit counter.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Derived widths for the default geometry.
  localparam int ROW_W  = DEF_DATA_WIDTH * DEF_TOKEN_DIM;
  localparam int MAT_W  = ROW_W * DEF_TOKEN_NUM;
  localparam int IDX_W  = clog2_min1(DEF_TOKEN_NUM);
  localparam int HOLD_W = clog2_min1(DEF_MIN_HOLD + 1);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

endpackage : attn_pkg
`default_nettype wire

// File: rtl/attn_row_bank.sv
`default_nettype none
// ============================================================================
// Module      : attn_row_bank
// Description : Matrix register organised as ROWS rows of ROW_W bits with a
//               row-indexed write and an asynchronous active-low clear.
// Ports       : clk        - clock
//               rst_n      - asynchronous active-low clear
//               we_i       - write enable for row row_i
//               row_i      - row index to write
//               row_data_i - row contents
//               mat_o      - flat matrix, row r at [r*ROW_W +: ROW_W]
// Revision    : 1.0 - initial release
// ============================================================================
module attn_row_bank
  import attn_pkg::*;
#(
  parameter int ROW_W = 192,
  parameter int ROWS  = 8,
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      row_i,
  input  logic [ROW_W-1:0]      row_data_i,
  output logic [ROW_W*ROWS-1:0] mat_o
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [ROW_W-1:0] row_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        row_q <= '0;
      end else if (we_i && (row_i == IDX_W'(r))) begin
        row_q <= row_data_i;
      end
    end

    assign mat_o[r*ROW_W +: ROW_W] = row_q;
  end

endmodule : attn_row_bank
`default_nettype wire

// File: rtl/attn_token_loader.sv
`default_nettype none
// ============================================================================
// Module      : attn_token_loader
// Description : Serial Q/K/V token loader with ping-pong banks. One bank
//               fills from the beat stream while the other drives the flat
//               Q/K/V matrices; banks swap only after a minimum hold time.
// Ports       : clk, rst_n              - clock, async active-low reset
//               in_valid/in_ready       - beat handshake
//               in_last                 - final beat of a frame
//               in_q/in_k/in_v          - one token row per beat
//               Q_out/K_out/V_out       - presented matrices
//               out_valid               - a complete frame is presented
//               frame_start             - pulse on the first presented cycle
//               frame_id                - frames presented, wraps at 256
//               err_frame               - pulse on a framing error
// Revision    : 1.0 - initial release
// ============================================================================
module attn_token_loader
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TOKEN_DIM  = DEF_TOKEN_DIM,
  parameter int TOKEN_NUM  = DEF_TOKEN_NUM,
  parameter int MIN_HOLD   = DEF_MIN_HOLD
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_last,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]       in_q,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]       in_k,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]       in_v,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] Q_out,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] K_out,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V_out,
  output logic                                  out_valid,
  output logic                                  frame_start,
  output logic [7:0]                            frame_id,
  output logic                                  err_frame
);

  localparam int ROW_BITS  = DATA_WIDTH * TOKEN_DIM;
  localparam int BANK_ROW  = 3 * ROW_BITS;          // {V, K, Q} per token
  localparam int IDX_BITS  = clog2_min1(TOKEN_NUM);
  localparam int HOLD_BITS = clog2_min1(MIN_HOLD + 1);

  localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(TOKEN_NUM - 1);
  localparam logic [HOLD_BITS-1:0] HOLD_MAX = HOLD_BITS'(MIN_HOLD);

  state_t               state_q, state_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;
  logic                 bank_sel_q, bank_sel_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_start_q, frame_start_d;
  logic [7:0]           frame_id_q, frame_id_d;
  logic                 err_q, err_d;
  logic                 w_we;

  logic [BANK_ROW*TOKEN_NUM-1:0] w_bank0_mat, w_bank1_mat, w_sel_mat;
  logic [BANK_ROW-1:0]           w_row_data;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bank_sel_d    = bank_sel_q;
    out_valid_d   = out_valid_q;
    frame_id_d    = frame_id_q;
    frame_start_d = 1'b0;
    err_d         = 1'b0;
    w_we          = 1'b0;
    hold_cnt_d    = (hold_cnt_q < HOLD_MAX) ? hold_cnt_q + 1'b1 : hold_cnt_q;

    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          w_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            // Full row count reached: commit even without in_last, but flag it.
            idx_d   = '0;
            state_d = S_FULL;
            err_d   = ~in_last;
          end else if (in_last) begin
            // Short frame: drop it; the presented bank is never touched.
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FULL: begin
        if (hold_cnt_q == HOLD_MAX) begin
          bank_sel_d    = ~bank_sel_q;
          hold_cnt_d    = '0;
          out_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          frame_id_d    = frame_id_q + 8'd1;
          state_d       = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FILL;
      idx_q         <= '0;
      hold_cnt_q    <= HOLD_MAX;   // first frame may swap immediately
      bank_sel_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_id_q    <= 8'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hold_cnt_q    <= hold_cnt_d;
      bank_sel_q    <= bank_sel_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      frame_id_q    <= frame_id_d;
      err_q         <= err_d;
    end
  end

  assign w_row_data = {in_v, in_k, in_q};

  // The fill bank is the one not selected for presentation.
  attn_row_bank #(.ROW_W(BANK_ROW), .ROWS(TOKEN_NUM), .IDX_W(IDX_BITS)) u_bank0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (w_we & bank_sel_q),
    .row_i      (idx_q),
    .row_data_i (w_row_data),
    .mat_o      (w_bank0_mat)
  );

  attn_row_bank #(.ROW_W(BANK_ROW), .ROWS(TOKEN_NUM), .IDX_W(IDX_BITS)) u_bank1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (w_we & ~bank_sel_q),
    .row_i      (idx_q),
    .row_data_i (w_row_data),
    .mat_o      (w_bank1_mat)
  );

  // Selector and presented bank are both flops that only change on a swap
  // edge, so the outputs move once per frame.
  assign w_sel_mat = bank_sel_q ? w_bank1_mat : w_bank0_mat;

  for (genvar r = 0; r < TOKEN_NUM; r++) begin : g_unpack
    assign Q_out[r*ROW_BITS +: ROW_BITS] = w_sel_mat[r*BANK_ROW              +: ROW_BITS];
    assign K_out[r*ROW_BITS +: ROW_BITS] = w_sel_mat[r*BANK_ROW + ROW_BITS   +: ROW_BITS];
    assign V_out[r*ROW_BITS +: ROW_BITS] = w_sel_mat[r*BANK_ROW + 2*ROW_BITS +: ROW_BITS];
  end

  assign in_ready    = (state_q == S_FILL);
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign frame_id    = frame_id_q;
  assign err_frame   = err_q;

endmodule : attn_token_loader
`default_nettype wire
